// File: rtl/m_dm_resp.sv
`default_nettype none
// ============================================================================
// Module   : m_dm_resp
// Brief    : M-stage data-memory responder. Merges lane-aligned store data
//            into a word-organised memory, returns the raw word and the
//            aligned/extended load result, and logs each committed store.
// Revision : 1.0 - initial release
// ============================================================================
module m_dm_resp #(
  parameter int WORDS = 3072,
  parameter int IDX_W = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_data_addr,
  input  logic [3:0]  m_data_byteen,
  input  logic [31:0] m_data_wdata,
  input  logic [31:0] m_inst_addr,
  input  logic [2:0]  DEOp,
  output logic [31:0] m_data_rdata,
  output logic [31:0] load_data,
  output logic        wlog_valid,
  output logic [31:0] wlog_pc,
  output logic [31:0] wlog_addr,
  output logic [31:0] wlog_data
);

  localparam logic [IDX_W:0] WORDS_L = (IDX_W + 1)'(WORDS);

  localparam logic [2:0] OP_LBU = 3'd1;
  localparam logic [2:0] OP_LB  = 3'd2;
  localparam logic [2:0] OP_LHU = 3'd3;
  localparam logic [2:0] OP_LH  = 3'd4;

  logic [31:0]      mem [WORDS];
  logic [IDX_W-1:0] idx;
  logic             in_range;
  logic [31:0]      merged;
  logic             commit;
  logic [1:0]       a;
  logic [7:0]       sel_byte;
  logic [15:0]      sel_half;

  assign idx      = m_data_addr[IDX_W+1:2];
  // Upper address bits must be clear and the index must land inside the array.
  assign in_range = (m_data_addr[31:IDX_W+2] == '0) && ({1'b0, idx} < WORDS_L);
  // Out-of-range reads return zero rather than aliasing onto a real word.
  assign m_data_rdata = in_range ? mem[idx] : 32'h0;
  assign commit = !reset && (m_data_byteen != 4'b0000) && in_range;
  assign a      = m_data_addr[1:0];

  // Byte-lane merge of the store data over the current (pre-write) word.
  always_comb begin
    merged = m_data_rdata;
    for (int i = 0; i < 4; i++) begin
      if (m_data_byteen[i]) merged[8*i +: 8] = m_data_wdata[8*i +: 8];
    end
  end

  // Load alignment and extension; a[0] is ignored for halfword ops.
  always_comb begin
    sel_byte  = m_data_rdata[8*a +: 8];
    sel_half  = a[1] ? m_data_rdata[31:16] : m_data_rdata[15:0];
    load_data = m_data_rdata;
    case (DEOp)
      OP_LBU:  load_data = {24'h0, sel_byte};
      OP_LB:   load_data = {{24{sel_byte[7]}}, sel_byte};
      OP_LHU:  load_data = {16'h0, sel_half};
      OP_LH:   load_data = {{16{sel_half[15]}}, sel_half};
      default: load_data = m_data_rdata;
    endcase
  end

  // Memory update and store log; reset wipes every word and beats any store.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= 32'h0;
      wlog_valid <= 1'b0;
      wlog_pc    <= 32'h0;
      wlog_addr  <= 32'h0;
      wlog_data  <= 32'h0;
    end else begin
      wlog_valid <= commit;
      if (commit) begin
        mem[idx]  <= merged;
        wlog_pc   <= m_inst_addr;
        wlog_addr <= {m_data_addr[31:2], 2'b00};
        wlog_data <= merged;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_m_dm_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_m_dm_resp
// Brief    : Directed bench for m_dm_resp with a byte-addressed reference
//            memory model and per-cycle comparison of all outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_m_dm_resp;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m_data_addr;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_data_wdata;
  logic [31:0] m_inst_addr;
  logic [2:0]  DEOp;
  logic [31:0] m_data_rdata;
  logic [31:0] load_data;
  logic        wlog_valid;
  logic [31:0] wlog_pc;
  logic [31:0] wlog_addr;
  logic [31:0] wlog_data;

  int checks = 0;
  int errors = 0;
  bit model_on = 1'b0;

  // Reference: flat byte memory covering 0x0000-0x2FFF.
  logic [7:0]  bmem [0:12287];
  logic        exp_valid;
  logic [31:0] exp_pc, exp_addr, exp_data;

  m_dm_resp dut (
    .clk(clk), .reset(reset), .m_data_addr(m_data_addr),
    .m_data_byteen(m_data_byteen), .m_data_wdata(m_data_wdata),
    .m_inst_addr(m_inst_addr), .DEOp(DEOp), .m_data_rdata(m_data_rdata),
    .load_data(load_data), .wlog_valid(wlog_valid), .wlog_pc(wlog_pc),
    .wlog_addr(wlog_addr), .wlog_data(wlog_data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mbyte(input logic [31:0] byte_addr);
    if (byte_addr < 32'h3000) return bmem[byte_addr];
    return 8'h00;
  endfunction

  function automatic logic [31:0] mword(input logic [31:0] addr);
    logic [31:0] base;
    base = {addr[31:2], 2'b00};
    return {mbyte(base + 3), mbyte(base + 2), mbyte(base + 1), mbyte(base)};
  endfunction

  function automatic logic [31:0] mload(input logic [31:0] addr, input logic [2:0] op);
    logic [31:0] base;
    logic [7:0]  b;
    logic [15:0] h;
    base = {addr[31:2], 2'b00};
    b = mbyte(base + {30'b0, addr[1:0]});
    h = addr[1] ? {mbyte(base + 3), mbyte(base + 2)} : {mbyte(base + 1), mbyte(base)};
    case (op)
      3'd1: return {24'h0, b};
      3'd2: return (b >= 8'h80) ? (32'hFFFFFF00 | {24'h0, b}) : {24'h0, b};
      3'd3: return {16'h0, h};
      3'd4: return (h >= 16'h8000) ? (32'hFFFF0000 | {16'h0, h}) : {16'h0, h};
      default: return mword(addr);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state advances on each rising edge from the inputs held there.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 12288; i++) bmem[i] = 8'h00;
      exp_valid = 1'b0; exp_pc = 0; exp_addr = 0; exp_data = 0;
    end else if (m_data_byteen != 4'b0 && m_data_addr < 32'h3000) begin
      for (int i = 0; i < 4; i++)
        if (m_data_byteen[i])
          bmem[{m_data_addr[31:2], 2'b00} + i] = m_data_wdata[8*i +: 8];
      exp_valid = 1'b1;
      exp_pc    = m_inst_addr;
      exp_addr  = {m_data_addr[31:2], 2'b00};
      exp_data  = mword(m_data_addr);
    end else begin
      exp_valid = 1'b0;
    end
  end

  // Per-cycle comparison against the model once it has been reset.
  always @(negedge clk) begin
    if (model_on) begin
      chk("rdata", m_data_rdata, mword(m_data_addr));
      chk("load_data", load_data, mload(m_data_addr, DEOp));
      chk("wlog_valid", {31'b0, wlog_valid}, {31'b0, exp_valid});
      chk("wlog_pc", wlog_pc, exp_pc);
      chk("wlog_addr", wlog_addr, exp_addr);
      chk("wlog_data", wlog_data, exp_data);
    end
  end

  task automatic step(input logic rst, input logic [31:0] addr, input logic [3:0] be,
                      input logic [31:0] wd, input logic [31:0] pc, input logic [2:0] op);
    @(posedge clk);
    #1;
    reset = rst; m_data_addr = addr; m_data_byteen = be;
    m_data_wdata = wd; m_inst_addr = pc; DEOp = op;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; m_data_addr = 0; m_data_byteen = 0;
    m_data_wdata = 0; m_inst_addr = 0; DEOp = 0;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    model_on = 1'b1;

    // Reset state reads
    step(0, 32'h0000, 0, 0, 0, 0);
    chk("lit_rst_rdata0", m_data_rdata, 32'h0);
    chk("lit_rst_load0", load_data, 32'h0);
    chk("lit_rst_valid", {31'b0, wlog_valid}, 32'h0);
    step(0, 32'h2FFC, 0, 0, 0, 0);
    chk("lit_rst_rdata_top", m_data_rdata, 32'h0);

    // Word store then back-to-back byte store to the same word
    step(0, 32'h0010, 4'b1111, 32'h8899AABB, 32'h3000, 0);
    chk("lit_prewrite", m_data_rdata, 32'h0);
    step(0, 32'h0012, 4'b0100, 32'h00120000, 32'h3004, 0);
    chk("lit_log1_valid", {31'b0, wlog_valid}, 32'h1);
    chk("lit_log1_pc", wlog_pc, 32'h3000);
    chk("lit_log1_addr", wlog_addr, 32'h10);
    chk("lit_log1_data", wlog_data, 32'h8899AABB);
    step(0, 32'h0013, 0, 0, 0, 3'd2);
    chk("lit_log2_valid", {31'b0, wlog_valid}, 32'h1);
    chk("lit_log2_data", wlog_data, 32'h8812AABB);
    chk("lit_lb", load_data, 32'hFFFFFF88);
    step(0, 32'h0013, 0, 0, 0, 3'd1);
    chk("lit_lbu", load_data, 32'h00000088);
    chk("lit_idle_valid", {31'b0, wlog_valid}, 32'h0);
    step(0, 32'h0012, 0, 0, 0, 3'd4);
    chk("lit_lh", load_data, 32'hFFFF8812);
    step(0, 32'h0010, 0, 0, 0, 3'd3);
    chk("lit_lhu", load_data, 32'h0000AABB);
    step(0, 32'h0011, 0, 0, 0, 3'd1);
    chk("lit_lbu_lane1", load_data, 32'h000000AA);
    step(0, 32'h0011, 0, 0, 0, 3'd7);
    chk("lit_op7_word", load_data, 32'h8812AABB);

    // Read during write to the same word
    step(0, 32'h0020, 4'b1111, 32'h00000001, 32'h3008, 0);
    chk("lit_rdw_old", m_data_rdata, 32'h0);
    step(0, 32'h0020, 0, 0, 0, 0);
    chk("lit_rdw_new", m_data_rdata, 32'h1);

    // Out-of-range store is dropped
    step(0, 32'h3000, 4'b1111, 32'h12345678, 32'h300C, 0);
    chk("lit_oor_rd", m_data_rdata, 32'h0);
    step(0, 32'h3000, 0, 0, 0, 0);
    chk("lit_oor_nolog", {31'b0, wlog_valid}, 32'h0);
    chk("lit_oor_rd2", m_data_rdata, 32'h0);
    step(0, 32'h0000, 0, 0, 0, 0);
    chk("lit_word0", m_data_rdata, 32'h0);
    step(0, 32'h4000_0010, 4'b1111, 32'hCAFEF00D, 32'h3010, 0);
    step(0, 32'h0010, 0, 0, 0, 0);
    chk("lit_hiaddr_nolog", {31'b0, wlog_valid}, 32'h0);
    chk("lit_hiaddr_alias", m_data_rdata, 32'h8812AABB);

    // Store then reset with a store pending
    step(0, 32'h0040, 4'b1111, 32'hDEADBEEF, 32'h3014, 0);
    step(1, 32'h0044, 4'b1111, 32'h00000005, 32'h3018, 0);
    chk("lit_pre_rst_log", wlog_data, 32'hDEADBEEF);
    step(0, 32'h0040, 0, 0, 0, 0);
    chk("lit_rst_mem", m_data_rdata, 32'h0);
    chk("lit_rst_valid2", {31'b0, wlog_valid}, 32'h0);
    chk("lit_rst_pc", wlog_pc, 32'h0);
    step(0, 32'h0044, 0, 0, 0, 0);
    chk("lit_rst_drop", m_data_rdata, 32'h0);

    // First cycle after reset is a normal store
    step(0, 32'h0044, 4'b0011, 32'h0000BEEF, 32'h301C, 3'd4);
    step(0, 32'h0044, 0, 0, 0, 3'd4);
    chk("lit_post_rst_lh", load_data, 32'hFFFFBEEF);
    step(0, 32'h0010, 0, 0, 0, 0);
    chk("lit_post_rst_word10", m_data_rdata, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
